inst_fetch_queue: RTL and testbench

- Sits directly downstream of the program-counter stage. Accepts PC values and issues them to the synchronous instruction ROM.
- Captures returned 9-bit instructions with their PC into a small FIFO and presents them to decode over a valid/ready handshake.
- Taken branches (Flush) and program start (Start) discard all queued and in-flight instructions, so decode never executes a wrong-path instruction.

---
 rtl/ifq_pkg.sv | 21 ++
 rtl/ifq_storage.sv | 70 +++++++
 rtl/inst_fetch_queue.sv | 113 +++++++++++
 tb/tb_inst_fetch_queue.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifq_pkg.sv
// rtl/ifq_pkg.sv - shared types and defaults for the instruction fetch queue
package ifq_pkg;

    localparam int IFQ_DEPTH = 4;
    localparam int IFQ_IW    = 9;
    localparam int IFQ_AW    = 10;

    typedef logic [IFQ_IW-1:0] inst_t;
    typedef logic [IFQ_AW-1:0] pc_t;

    typedef struct packed {
        inst_t inst;
        pc_t   pc;
    } ifq_entry_t;

    typedef enum logic {
        IFQ_IDLE = 1'b0,
        IFQ_WAIT = 1'b1
    } ifq_fetch_state_t;

endpackage

// File: rtl/ifq_storage.sv
// rtl/ifq_storage.sv - register-array FIFO holding (instruction, PC) pairs
module ifq_storage
    import ifq_pkg::*;
#(
    parameter int  DEPTH = IFQ_DEPTH,
    parameter int  IW    = IFQ_IW,
    parameter int  AW    = IFQ_AW,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clear_i,
    input  logic          push_i,
    input  logic [IW-1:0] push_inst_i,
    input  logic [AW-1:0] push_pc_i,
    input  logic          pop_i,
    output logic [IW-1:0] head_inst_o,
    output logic [AW-1:0] head_pc_o,
    output logic [CW-1:0] count_o
);

    logic [IW-1:0] inst_q [DEPTH];
    logic [AW-1:0] pc_q   [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    // Pointers wrap naturally; full vs empty is told apart by count alone.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
            if (push_i && !pop_i)      count_d = count_q + CW'(1);
            else if (!push_i && pop_i) count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                inst_q[i] <= '0;
                pc_q[i]   <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push_i && !clear_i) begin
                inst_q[wr_ptr_q] <= push_inst_i;
                pc_q[wr_ptr_q]   <= push_pc_i;
            end
        end
    end

    assign head_inst_o = inst_q[rd_ptr_q];
    assign head_pc_o   = pc_q[rd_ptr_q];
    assign count_o     = count_q;

endmodule

// File: rtl/inst_fetch_queue.sv
// rtl/inst_fetch_queue.sv - PC-to-ROM fetch tracking and decode queue; IFQ_BYPASS_EN enables 1-cycle bypass
module inst_fetch_queue
    import ifq_pkg::*;
#(
    parameter int  DEPTH = IFQ_DEPTH,
    parameter int  IW    = IFQ_IW,
    parameter int  AW    = IFQ_AW,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic          Flush,
    input  logic [AW-1:0] ProgCtr,
    input  logic          FetchValid,
    output logic          FetchReady,
    output logic [AW-1:0] ImemAddr,
    output logic          ImemRd,
    input  logic [IW-1:0] ImemData,
    output logic [IW-1:0] InstOut,
    output logic [AW-1:0] InstPC,
    output logic          InstValid,
    input  logic          InstReady,
    output logic [CW-1:0] Count
);

    localparam int OW = CW + 1;

    ifq_fetch_state_t state_q, state_d;
    logic [AW-1:0]    inflight_pc_q;
    logic             alive_q;
    logic             inflight_v;
    logic             kill;
    logic             has_data;
    logic             bypass_v;
    logic             push;
    logic             pop;
    logic [OW-1:0]    occupancy;
    logic [IW-1:0]    head_inst;
    logic [AW-1:0]    head_pc;

    assign kill      = Flush | Start;
    assign has_data  = (Count != '0);
    assign occupancy = {1'b0, Count} + OW'(inflight_v);

    // Readiness depends on registered occupancy only, never on InstReady.
    assign FetchReady = alive_q & ~kill & (occupancy < OW'(DEPTH));
    assign ImemRd     = FetchValid & FetchReady;
    assign ImemAddr   = ProgCtr;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) state_q <= IFQ_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IFQ_IDLE: if (ImemRd) state_d = IFQ_WAIT;
            IFQ_WAIT: state_d = ImemRd ? IFQ_WAIT : IFQ_IDLE;
            default:  state_d = IFQ_IDLE;
        endcase
        if (kill) state_d = IFQ_IDLE;
    end

    always_comb begin
        inflight_v = (state_q == IFQ_WAIT);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            inflight_pc_q <= '0;
            alive_q       <= 1'b0;
        end else begin
            alive_q <= 1'b1;
            if (ImemRd) inflight_pc_q <= ProgCtr;
        end
    end

`ifdef IFQ_BYPASS_EN
    assign bypass_v  = inflight_v & ~has_data & ~kill;
    assign InstValid = has_data | bypass_v;
    assign InstOut   = bypass_v ? ImemData : head_inst;
    assign InstPC    = bypass_v ? inflight_pc_q : head_pc;
`else
    assign bypass_v  = 1'b0;
    assign InstValid = has_data;
    assign InstOut   = head_inst;
    assign InstPC    = head_pc;
`endif

    // A bypassed instruction consumed in its arrival cycle is never stored.
    assign push = inflight_v & ~kill & ~(bypass_v & InstReady);
    assign pop  = has_data & InstReady & ~kill;

    ifq_storage #(
        .DEPTH (DEPTH),
        .IW    (IW),
        .AW    (AW)
    ) u_storage (
        .clk_i       (Clk),
        .rst_ni      (Reset),
        .clear_i     (kill),
        .push_i      (push),
        .push_inst_i (ImemData),
        .push_pc_i   (inflight_pc_q),
        .pop_i       (pop),
        .head_inst_o (head_inst),
        .head_pc_o   (head_pc),
        .count_o     (Count)
    );

endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb/tb_inst_fetch_queue.sv - randomized and directed checks against a queue-based fetch model
module tb_inst_fetch_queue;

    localparam int DEPTH = 4;
    localparam int IW    = 9;
    localparam int AW    = 10;
    localparam int CW    = 3;
`ifdef IFQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic          Start = 1'b0;
    logic          Flush = 1'b0;
    logic [AW-1:0] ProgCtr = '0;
    logic          FetchValid = 1'b0;
    logic          FetchReady;
    logic [AW-1:0] ImemAddr;
    logic          ImemRd;
    logic [IW-1:0] ImemData = '0;
    logic [IW-1:0] InstOut;
    logic [AW-1:0] InstPC;
    logic          InstValid;
    logic          InstReady = 1'b0;
    logic [CW-1:0] Count;

    inst_fetch_queue dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Start      (Start),
        .Flush      (Flush),
        .ProgCtr    (ProgCtr),
        .FetchValid (FetchValid),
        .FetchReady (FetchReady),
        .ImemAddr   (ImemAddr),
        .ImemRd     (ImemRd),
        .ImemData   (ImemData),
        .InstOut    (InstOut),
        .InstPC     (InstPC),
        .InstValid  (InstValid),
        .InstReady  (InstReady),
        .Count      (Count)
    );

    always #5 Clk = ~Clk;

    function automatic logic [IW-1:0] rom(input logic [AW-1:0] pc);
        return pc[IW-1:0] + 9'h100;
    endfunction

    // ROM answers one cycle after a read; otherwise the bus carries junk.
    always @(posedge Clk) ImemData <= ImemRd ? rom(ImemAddr) : IW'($urandom);

    logic [AW-1:0] mq[$];
    bit            m_infl;
    bit            m_alive;
    logic [AW-1:0] m_infl_pc;

    bit            e_byp, e_valid, e_fready, e_rd;
    int            e_count;
    logic [AW-1:0] e_pc;
    logic [IW-1:0] e_inst;

    int checks = 0;
    int failures = 0;

    task automatic drive(input bit fv, input logic [AW-1:0] pc, input bit rdy, input bit fl, input bit st);
        FetchValid = fv; ProgCtr = pc; InstReady = rdy; Flush = fl; Start = st;
        #1;
        e_byp    = BYP && mq.size() == 0 && m_infl && !fl && !st;
        e_count  = mq.size();
        e_valid  = (mq.size() != 0) || e_byp;
        e_pc     = (mq.size() != 0) ? mq[0] : m_infl_pc;
        e_inst   = rom(e_pc);
        e_fready = m_alive && !fl && !st && (mq.size() + int'(m_infl) < DEPTH);
        e_rd     = fv && e_fready;
    endtask

    task automatic tick();
        @(posedge Clk);
        if (Reset) begin
            if (Flush || Start) begin
                mq.delete();
                m_infl = 1'b0;
            end else begin
                if (mq.size() != 0 && InstReady) void'(mq.pop_front());
                if (m_infl && !(e_byp && InstReady)) mq.push_back(m_infl_pc);
                m_infl    = e_rd;
                m_infl_pc = ProgCtr;
            end
            m_alive = 1'b1;
        end
        @(negedge Clk);
    endtask

    task automatic model_reset();
        mq.delete();
        m_infl = 1'b0;
        m_alive = 1'b0;
        m_infl_pc = '0;
    endtask

    task automatic test_reset();
        #2 Reset = 1'b0;
        model_reset();
        @(negedge Clk);
        drive(1, 10'd0, 0, 0, 0);
        checks++; if (FetchReady !== 1'b0) begin failures++; $display("FAIL reset_fready got=%b exp=0", FetchReady); end
        checks++; if (InstValid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", InstValid); end
        checks++; if (Count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", Count); end
        checks++; if (InstOut !== 9'd0 || InstPC !== 10'd0) begin failures++; $display("FAIL reset_head got=%h/%h exp=0/0", InstOut, InstPC); end
        checks++; if (ImemRd !== 1'b0) begin failures++; $display("FAIL reset_rd got=%b exp=0", ImemRd); end
        Reset = 1'b1;
        drive(0, 10'd0, 0, 0, 0);
        checks++; if (FetchReady !== 1'b0) begin failures++; $display("FAIL release_fready_pre got=%b exp=0", FetchReady); end
        tick();
        drive(0, 10'd0, 0, 0, 0);
        checks++; if (FetchReady !== 1'b1) begin failures++; $display("FAIL release_fready_post got=%b exp=1", FetchReady); end
    endtask

    task automatic test_stream();
        for (int i = 0; i < 8; i++) begin
            drive(i < 4, AW'(i), 1, 0, 0);
            checks++; if (ImemRd !== e_rd) begin failures++; $display("FAIL stream_rd cyc=%0d got=%b exp=%b", i, ImemRd, e_rd); end
            checks++; if (InstValid !== e_valid) begin failures++; $display("FAIL stream_valid cyc=%0d got=%b exp=%b", i, InstValid, e_valid); end
            if (e_valid) begin
                checks++;
                if (InstPC !== e_pc || InstOut !== e_inst) begin
                    failures++; $display("FAIL stream_head cyc=%0d got=%h/%h exp=%h/%h", i, InstPC, InstOut, e_pc, e_inst);
                end
            end
            tick();
        end
    endtask

    task automatic test_fill();
        logic [AW-1:0] pc;
        int rd_seen;
        pc = '0;
        rd_seen = 0;
        for (int i = 0; i < 10; i++) begin
            drive(1, pc, 0, 0, 0);
            if (ImemRd === 1'b1) rd_seen++;
            checks++; if (ImemRd !== e_rd) begin failures++; $display("FAIL fill_rd cyc=%0d got=%b exp=%b", i, ImemRd, e_rd); end
            checks++; if (FetchReady !== e_fready) begin failures++; $display("FAIL fill_fready cyc=%0d got=%b exp=%b", i, FetchReady, e_fready); end
            checks++; if (Count !== CW'(e_count)) begin failures++; $display("FAIL fill_count cyc=%0d got=%0d exp=%0d", i, Count, e_count); end
            if (e_rd) pc++;
            tick();
        end
        drive(1, pc, 0, 0, 0);
        checks++; if (Count !== 3'd4) begin failures++; $display("FAIL fill_saturate got=%0d exp=4", Count); end
        checks++; if (rd_seen != 4) begin failures++; $display("FAIL fill_rd_total got=%0d exp=4", rd_seen); end
    endtask

    task automatic test_full_pop();
        drive(1, 10'd4, 1, 0, 0);
        checks++; if (InstPC !== 10'd0 || InstValid !== 1'b1) begin failures++; $display("FAIL fullpop_head got=%h v=%b exp=0 v=1", InstPC, InstValid); end
        checks++; if (FetchReady !== 1'b0) begin failures++; $display("FAIL fullpop_fready_same got=%b exp=0", FetchReady); end
        tick();
        drive(1, 10'd4, 0, 0, 0);
        checks++; if (FetchReady !== 1'b1 || ImemRd !== 1'b1) begin failures++; $display("FAIL fullpop_accept got=%b/%b exp=1/1", FetchReady, ImemRd); end
        checks++; if (InstPC !== 10'd1) begin failures++; $display("FAIL fullpop_next got=%h exp=1", InstPC); end
        tick();
        for (int i = 0; i < 6; i++) begin
            drive(0, 10'd0, 1, 0, 0);
            checks++; if (InstValid !== e_valid) begin failures++; $display("FAIL drain_valid cyc=%0d got=%b exp=%b", i, InstValid, e_valid); end
            if (e_valid) begin
                checks++; if (InstPC !== e_pc) begin failures++; $display("FAIL drain_pc cyc=%0d got=%h exp=%h", i, InstPC, e_pc); end
            end
            tick();
        end
    endtask

    task automatic test_flush();
        drive(0, 10'd0, 0, 1, 0); tick();
        drive(1, 10'd3, 0, 0, 0); tick();
        drive(1, 10'd4, 0, 0, 0); tick();
        drive(1, 10'd5, 0, 0, 0); tick();
        drive(0, 10'd0, 1, 1, 0);
        checks++; if (Count !== 3'd2) begin failures++; $display("FAIL flush_pre_count got=%0d exp=2", Count); end
        checks++; if (ImemRd !== 1'b0 || FetchReady !== 1'b0) begin failures++; $display("FAIL flush_rd got=%b/%b exp=0/0", ImemRd, FetchReady); end
        tick();
        drive(1, 10'd12, 1, 0, 0);
        checks++; if (Count !== 3'd0 || InstValid !== 1'b0) begin failures++; $display("FAIL flush_post got=%0d/%b exp=0/0", Count, InstValid); end
        checks++; if (ImemRd !== 1'b1) begin failures++; $display("FAIL flush_refetch got=%b exp=1", ImemRd); end
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(0, 10'd0, 1, 0, 0);
            checks++; if (InstValid !== e_valid) begin failures++; $display("FAIL flush_emerge_valid cyc=%0d got=%b exp=%b", i, InstValid, e_valid); end
            if (e_valid) begin
                checks++; if (InstPC !== e_pc) begin failures++; $display("FAIL flush_emerge_pc cyc=%0d got=%h exp=%h", i, InstPC, e_pc); end
            end
            checks++; if (InstValid === 1'b1 && InstPC === 10'd5) begin failures++; $display("FAIL flush_wrong_path got=%h exp=not5", InstPC); end
            tick();
        end
    endtask

    task automatic test_start();
        for (int i = 0; i < 3; i++) begin
            drive(1, 10'd20, 0, 0, 1);
            checks++; if (ImemRd !== 1'b0 || FetchReady !== 1'b0) begin failures++; $display("FAIL start_hold cyc=%0d got=%b/%b exp=0/0", i, ImemRd, FetchReady); end
            tick();
        end
        drive(1, 10'd20, 1, 0, 0);
        checks++; if (ImemRd !== 1'b1) begin failures++; $display("FAIL start_resume got=%b exp=1", ImemRd); end
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(0, 10'd0, 1, 0, 0);
            checks++; if (InstValid !== e_valid) begin failures++; $display("FAIL start_emerge cyc=%0d got=%b exp=%b", i, InstValid, e_valid); end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) begin
            drive(1, AW'(30 + i), 0, 0, 0);
            tick();
        end
        drive(0, 10'd0, 0, 0, 0);
        checks++; if (Count !== 3'd3) begin failures++; $display("FAIL midreset_pre got=%0d exp=3", Count); end
        #2 Reset = 1'b0;
        model_reset();
        #1;
        checks++; if (Count !== 3'd0 || InstValid !== 1'b0) begin failures++; $display("FAIL midreset_clear got=%0d/%b exp=0/0", Count, InstValid); end
        checks++; if (FetchReady !== 1'b0) begin failures++; $display("FAIL midreset_fready got=%b exp=0", FetchReady); end
        @(negedge Clk);
        Reset = 1'b1;
        drive(0, 10'd0, 0, 0, 0);
        tick();
    endtask

`ifdef IFQ_BYPASS_EN
    task automatic test_bypass();
        drive(1, 10'd7, 0, 0, 0); tick();
        drive(0, 10'd0, 0, 0, 0);
        checks++; if (InstValid !== 1'b1 || InstPC !== 10'd7 || InstOut !== rom(10'd7)) begin failures++; $display("FAIL bypass_hold got=%b/%h/%h exp=1/007/%h", InstValid, InstPC, InstOut, rom(10'd7)); end
        checks++; if (Count !== 3'd0) begin failures++; $display("FAIL bypass_count got=%0d exp=0", Count); end
        tick();
        drive(0, 10'd0, 1, 0, 0);
        checks++; if (Count !== 3'd1 || InstPC !== 10'd7) begin failures++; $display("FAIL bypass_written got=%0d/%h exp=1/007", Count, InstPC); end
        tick();
        drive(1, 10'd8, 1, 0, 0); tick();
        drive(0, 10'd0, 1, 0, 0);
        checks++; if (InstValid !== 1'b1 || InstPC !== 10'd8) begin failures++; $display("FAIL bypass_take got=%b/%h exp=1/008", InstValid, InstPC); end
        tick();
        drive(0, 10'd0, 1, 0, 0);
        checks++; if (Count !== 3'd0 || InstValid !== 1'b0) begin failures++; $display("FAIL bypass_consumed got=%0d/%b exp=0/0", Count, InstValid); end
        tick();
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, AW'($urandom), $urandom_range(0, 1) == 1,
                  $urandom_range(0, 19) == 0, $urandom_range(0, 29) == 0);
            checks++; if (Count !== CW'(e_count)) begin failures++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", i, Count, e_count); end
            checks++; if (FetchReady !== e_fready) begin failures++; $display("FAIL rnd_fready cyc=%0d got=%b exp=%b", i, FetchReady, e_fready); end
            checks++; if (ImemRd !== e_rd) begin failures++; $display("FAIL rnd_rd cyc=%0d got=%b exp=%b", i, ImemRd, e_rd); end
            checks++; if (InstValid !== e_valid) begin failures++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", i, InstValid, e_valid); end
            if (e_valid) begin
                checks++;
                if (InstPC !== e_pc || InstOut !== e_inst) begin
                    failures++; $display("FAIL rnd_head cyc=%0d got=%h/%h exp=%h/%h", i, InstPC, InstOut, e_pc, e_inst);
                end
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_fill();
        test_full_pop();
        test_flush();
        test_start();
        test_reset_mid();
`ifdef IFQ_BYPASS_EN
        test_bypass();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
